// File: rtl/conv_mac_engine.sv
// conv_mac_engine: 1-D convolution engine. Slides a filter across an
// IFmap line held in internal scratchpads and streams one psum per window.
// Ports:
//   clk, rst                       clock, async active-high reset
//   if_wr_en/addr/data             IFmap scratchpad write (IDLE only)
//   filt_wr_en/addr/data           filter scratchpad write (IDLE only)
//   cfg_if_len/filter_len/stride   job config, latched on start
//   start                          job request, sampled in IDLE
//   psum_valid/ready/data          window result stream
//   busy, done, err                job status
module conv_mac_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int IF_DEPTH     = 16,
  parameter int FILTER_DEPTH = 8,
  parameter bit SATURATE     = 1'b0,
  parameter int IAW = $clog2(IF_DEPTH + 1),
  parameter int FAW = $clog2(FILTER_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_wr_en,
  input  logic [IAW-1:0]               if_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] if_wr_data,
  input  logic                         filt_wr_en,
  input  logic [FAW-1:0]               filt_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] filt_wr_data,
  input  logic [IAW-1:0]               cfg_if_len,
  input  logic [FAW-1:0]               cfg_filter_len,
  input  logic [IAW-1:0]               cfg_stride,
  input  logic                         start,
  output logic                         psum_valid,
  input  logic                         psum_ready,
  output logic signed [ACC_WIDTH-1:0]  psum_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int IIW = (IF_DEPTH > 1) ? $clog2(IF_DEPTH) : 1;
  localparam int FIW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
  localparam int WW  = ((IAW > FAW) ? IAW : FAW) + 2;
  localparam int PW  = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_MAC, S_DRAIN, S_OUT, S_FIN
  } state_e;

  state_e                        state_q;
  logic [IAW-1:0]                if_len_q;
  logic [IAW-1:0]                stride_q;
  logic [FAW-1:0]                len_q;
  logic [IIW-1:0]                head_q;
  logic [FIW-1:0]                idx_q;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          sat_q, sat_d;
  logic                          rd_vld_q;
  logic                          pv_q;
  logic signed [ACC_WIDTH-1:0]   pd_q;
  logic                          busy_q, done_q, err_q;

  logic signed [DATA_WIDTH-1:0]  if_mem [IF_DEPTH];
  logic signed [DATA_WIDTH-1:0]  filt_mem [FILTER_DEPTH];
  logic signed [DATA_WIDTH-1:0]  if_rd_q, f_rd_q;

  assign psum_valid = pv_q;
  assign psum_data  = pd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  // Config screening, done at common width to compare mixed fields.
  logic [WW-1:0] c_ilen, c_len, c_str;
  logic          cfg_bad;
  assign c_ilen = WW'(cfg_if_len);
  assign c_len  = WW'(cfg_filter_len);
  assign c_str  = WW'(cfg_stride);
  assign cfg_bad = (c_len == '0) || (c_len > WW'(FILTER_DEPTH)) ||
                   (c_len > c_ilen) || (c_str == '0) ||
                   (c_ilen == '0) || (c_ilen > WW'(IF_DEPTH));

  // Another window fits iff the advanced window still ends in range;
  // this is the same count as floor((len-L)/stride)+1 without a divider.
  logic [WW-1:0] nxt_head;
  logic          more_win;
  assign nxt_head = WW'(head_q) + WW'(stride_q);
  assign more_win = (nxt_head + WW'(len_q)) <= WW'(if_len_q);

  logic [IIW-1:0] rd_addr;
  logic           last_idx;
  assign rd_addr  = head_q + IIW'(idx_q);
  assign last_idx = (FAW'(idx_q) + FAW'(1)) == len_q;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_x;
  logic [ACC_WIDTH:0]          sum_w;
  logic                        ovf;
  assign prod   = if_rd_q * f_rd_q;
  assign prod_x = ACC_WIDTH'(prod);
  assign sum_w  = {acc_q[ACC_WIDTH-1], acc_q} +
                  {prod_x[ACC_WIDTH-1], prod_x};
  assign ovf    = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];

  // Accumulate the product read on the previous cycle; once clamped
  // the window keeps its clamp value.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (rd_vld_q && !sat_q) begin
      if (SATURATE && ovf) begin
        sat_d = 1'b1;
        acc_d = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        acc_d = sum_w[ACC_WIDTH-1:0];
      end
    end
  end

  // Scratchpads are not reset; their contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_IDLE) begin
      if (if_wr_en && if_wr_addr < IAW'(IF_DEPTH))
        if_mem[if_wr_addr[IIW-1:0]] <= if_wr_data;
      if (filt_wr_en && filt_wr_addr < FAW'(FILTER_DEPTH))
        filt_mem[filt_wr_addr[FIW-1:0]] <= filt_wr_data;
    end
    if (state_q == S_MAC) begin
      if_rd_q <= if_mem[rd_addr];
      f_rd_q  <= filt_mem[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      if_len_q <= '0;
      stride_q <= '0;
      len_q    <= '0;
      head_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      pv_q     <= 1'b0;
      pd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (cfg_bad) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end else begin
              if_len_q <= cfg_if_len;
              len_q    <= cfg_filter_len;
              stride_q <= cfg_stride;
              head_q   <= '0;
              state_q  <= S_CLR;
            end
          end
        end
        S_CLR: begin
          acc_q    <= '0;
          sat_q    <= 1'b0;
          idx_q    <= '0;
          rd_vld_q <= 1'b0;
          state_q  <= S_MAC;
        end
        S_MAC: begin
          acc_q    <= acc_d;
          sat_q    <= sat_d;
          rd_vld_q <= 1'b1;
          idx_q    <= idx_q + FIW'(1);
          if (last_idx) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          acc_q    <= acc_d;
          sat_q    <= sat_d;
          rd_vld_q <= 1'b0;
          pd_q     <= acc_d;
          pv_q     <= 1'b1;
          state_q  <= S_OUT;
        end
        S_OUT: begin
          if (psum_ready) begin
            pv_q <= 1'b0;
            if (more_win) begin
              head_q  <= IIW'(nxt_head);
              state_q <= S_CLR;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: scoreboard bench; three engines (24-bit wrap,
// 16-bit saturate, 16-bit wrap) share one stimulus stream.
module tb_conv_mac_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_wr_en;
  logic [4:0]        if_wr_addr;
  logic signed [7:0] if_wr_data;
  logic              filt_wr_en;
  logic [3:0]        filt_wr_addr;
  logic signed [7:0] filt_wr_data;
  logic [4:0]        cfg_if_len;
  logic [3:0]        cfg_filter_len;
  logic [4:0]        cfg_stride;
  logic              start;
  logic              psum_ready;
  logic              pv [3];
  logic              bz [3];
  logic              dn [3];
  logic              er [3];
  logic [23:0]       pd0;
  logic [15:0]       pd1, pd2;

  always #5 clk = ~clk;

  conv_mac_engine #(.ACC_WIDTH(24), .SATURATE(1'b0)) u_w24 (
    .clk(clk), .rst(rst),
    .if_wr_en(if_wr_en), .if_wr_addr(if_wr_addr), .if_wr_data(if_wr_data),
    .filt_wr_en(filt_wr_en), .filt_wr_addr(filt_wr_addr),
    .filt_wr_data(filt_wr_data),
    .cfg_if_len(cfg_if_len), .cfg_filter_len(cfg_filter_len),
    .cfg_stride(cfg_stride), .start(start),
    .psum_valid(pv[0]), .psum_ready(psum_ready), .psum_data(pd0),
    .busy(bz[0]), .done(dn[0]), .err(er[0]));

  conv_mac_engine #(.ACC_WIDTH(16), .SATURATE(1'b1)) u_s16 (
    .clk(clk), .rst(rst),
    .if_wr_en(if_wr_en), .if_wr_addr(if_wr_addr), .if_wr_data(if_wr_data),
    .filt_wr_en(filt_wr_en), .filt_wr_addr(filt_wr_addr),
    .filt_wr_data(filt_wr_data),
    .cfg_if_len(cfg_if_len), .cfg_filter_len(cfg_filter_len),
    .cfg_stride(cfg_stride), .start(start),
    .psum_valid(pv[1]), .psum_ready(psum_ready), .psum_data(pd1),
    .busy(bz[1]), .done(dn[1]), .err(er[1]));

  conv_mac_engine #(.ACC_WIDTH(16), .SATURATE(1'b0)) u_w16 (
    .clk(clk), .rst(rst),
    .if_wr_en(if_wr_en), .if_wr_addr(if_wr_addr), .if_wr_data(if_wr_data),
    .filt_wr_en(filt_wr_en), .filt_wr_addr(filt_wr_addr),
    .filt_wr_data(filt_wr_data),
    .cfg_if_len(cfg_if_len), .cfg_filter_len(cfg_filter_len),
    .cfg_stride(cfg_stride), .start(start),
    .psum_valid(pv[2]), .psum_ready(psum_ready), .psum_data(pd2),
    .busy(bz[2]), .done(dn[2]), .err(er[2]));

  int     n_chk = 0;
  int     n_fail = 0;
  int     n_hold = 0;
  int     rmode = 0;
  int     ifm [16];
  int     flt [8];
  int     aw [3] = '{24, 16, 16};
  bit     sm [3] = '{1'b0, 1'b1, 1'b0};
  longint exp_q [3][$];
  bit     ph [3];
  longint pdv [3];
  longint cur [3];

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Window sum from plain integer arithmetic: clamp at first overflow,
  // or reduce the exact sum modulo 2^w.
  function automatic longint model(int s, int l, int w, bit sat);
    longint acc = 0;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    for (int i = 0; i < l; i++) begin
      acc += longint'(ifm[s + i]) * longint'(flt[i]);
      if (sat && acc > hi) return hi;
      if (sat && acc < lo) return lo;
    end
    if (!sat) begin
      acc = acc & ((longint'(1) <<< w) - 1);
      if (acc > hi) acc -= (longint'(1) <<< w);
    end
    return acc;
  endfunction

  task automatic wr_if(input int a, input int d);
    if_wr_en = 1'b1;
    if_wr_addr = 5'(a);
    if_wr_data = 8'(d);
    @(posedge clk); #1;
    if_wr_en = 1'b0;
    if (a < 16) ifm[a] = d;
  endtask

  task automatic wr_flt(input int a, input int d);
    filt_wr_en = 1'b1;
    filt_wr_addr = 4'(a);
    filt_wr_data = 8'(d);
    @(posedge clk); #1;
    filt_wr_en = 1'b0;
    if (a < 8) flt[a] = d;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 3; i++) wr_flt(i, i + 1);
    for (int i = 0; i < 6; i++) wr_if(i, i + 1);
  endtask

  task automatic run_job(input int ilen, input int l, input int st,
                         input bit bad, input bit poke,
                         output int first);
    int lat;
    first = 0;
    if (!bad) begin
      for (int w = 0; w <= (ilen - l) / st; w++)
        for (int k = 0; k < 3; k++)
          exp_q[k].push_back(model(w * st, l, aw[k], sm[k]));
    end
    cfg_if_len = 5'(ilen);
    cfg_filter_len = 4'(l);
    cfg_stride = 5'(st);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    if (bad) begin
      chk(dn[0] && er[0], "err_done", longint'(dn[0]), 1);
      chk(dn[1] && er[1] && dn[2] && er[2], "err_done_all",
          longint'(er[1]), 1);
      chk(!pv[0], "err_no_psum", longint'(pv[0]), 0);
      @(posedge clk); #1;
      chk(!dn[0] && !er[0] && !bz[0], "err_pulse", longint'(dn[0]), 0);
      return;
    end
    chk(bz[0] && !dn[0], "busy_start", longint'(bz[0]), 1);
    while (!dn[0] && lat < 3000) begin
      if (first == 0 && pv[0]) first = lat;
      if (poke && lat == 3) begin
        start = 1'b1;
        if_wr_en = 1'b1;
        if_wr_addr = 5'd0;
        if_wr_data = 8'(~ifm[0]);
        filt_wr_en = 1'b1;
        filt_wr_addr = 4'd0;
        filt_wr_data = 8'(~flt[0]);
      end
      if (poke && lat == 4) begin
        start = 1'b0;
        if_wr_en = 1'b0;
        filt_wr_en = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk(dn[0] == 1'b1, "done_seen", longint'(lat), 0);
    chk(dn[1] && dn[2], "done_all", longint'(dn[1]), 1);
    chk(!er[0] && !er[1] && !er[2], "err_clear", longint'(er[0]), 0);
    for (int k = 0; k < 3; k++)
      chk(exp_q[k].size() == 0, "psum_count",
          longint'(exp_q[k].size()), 0);
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    @(posedge clk); #1;
    chk(!dn[0] && !bz[0], "done_pulse", longint'(dn[0]), 0);
  endtask

  // psum_ready driver: always-ready, random, or 10-cycle stall per psum.
  initial begin
    int stall = 0;
    psum_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: psum_ready = 1'b1;
        1: psum_ready = 1'($urandom_range(0, 1));
        default: begin
          if (pv[0] && stall < 10) begin
            psum_ready = 1'b0;
            stall++;
          end else begin
            psum_ready = 1'b1;
            if (!pv[0]) stall = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops on every handshake, checks hold while stalled.
  initial begin
    longint e;
    forever begin
      @(negedge clk);
      cur[0] = longint'($signed(pd0));
      cur[1] = longint'($signed(pd1));
      cur[2] = longint'($signed(pd2));
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          ph[k] = 1'b0;
        end else begin
          if (ph[k]) begin
            if (k == 0) n_hold++;
            chk(pv[k] && cur[k] == pdv[k], "psum_hold", cur[k], pdv[k]);
          end
          if (pv[k] && psum_ready) begin
            if (exp_q[k].size() == 0) begin
              chk(1'b0, "unexpected_psum", cur[k], 0);
            end else begin
              e = exp_q[k].pop_front();
              chk(cur[k] == e, $sformatf("psum_inst%0d", k), cur[k], e);
            end
          end
          ph[k] = pv[k] && !psum_ready;
          pdv[k] = cur[k];
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, il, l, st;
    rst = 1'b0;
    if_wr_en = 1'b0; if_wr_addr = '0; if_wr_data = '0;
    filt_wr_en = 1'b0; filt_wr_addr = '0; filt_wr_data = '0;
    cfg_if_len = '0; cfg_filter_len = '0; cfg_stride = '0;
    start = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(!pv[0] && !bz[0] && !dn[0] && !er[0], "reset_ctrl",
        longint'(bz[0]), 0);
    chk(pd0 == '0 && pd1 == '0, "reset_data", longint'(pd0), 0);
    rst = 1'b0;

    load_ramp();
    run_job(6, 3, 1, 1'b0, 1'b0, lat);
    chk(lat == 6, "first_valid_latency", longint'(lat), 6);
    run_job(6, 3, 2, 1'b0, 1'b0, lat);
    run_job(6, 3, 4, 1'b0, 1'b0, lat);

    wr_flt(0, -1);
    wr_if(0, 127);
    wr_if(1, -128);
    run_job(2, 1, 1, 1'b0, 1'b0, lat);

    for (int i = 0; i < 4; i++) begin
      wr_flt(i, -128);
      wr_if(i, -128);
    end
    run_job(4, 4, 1, 1'b0, 1'b0, lat);

    load_ramp();
    rmode = 2;
    n_hold = 0;
    run_job(6, 3, 1, 1'b0, 1'b1, lat);
    chk(n_hold >= 40, "stall_hold_cycles", longint'(n_hold), 40);
    rmode = 0;
    run_job(6, 3, 1, 1'b0, 1'b0, lat);

    run_job(6, 0, 1, 1'b1, 1'b0, lat);
    run_job(4, 5, 1, 1'b1, 1'b0, lat);
    run_job(6, 3, 0, 1'b1, 1'b0, lat);
    run_job(0, 1, 1, 1'b1, 1'b0, lat);
    run_job(17, 3, 1, 1'b1, 1'b0, lat);
    run_job(16, 9, 1, 1'b1, 1'b0, lat);

    rmode = 1;
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 16; i++) wr_if(i, $urandom_range(0, 255) - 128);
      for (int i = 0; i < 8; i++) wr_flt(i, $urandom_range(0, 255) - 128);
      wr_if($urandom_range(16, 31), $urandom_range(0, 255) - 128);
      wr_flt($urandom_range(8, 15), $urandom_range(0, 255) - 128);
      il = $urandom_range(1, 16);
      l = $urandom_range(1, (il < 8) ? il : 8);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31)
                                       : $urandom_range(1, 3);
      run_job(il, l, st, 1'b0, 1'($urandom_range(0, 1)), lat);
    end

    rmode = 0;
    cfg_if_len = 5'd10;
    cfg_filter_len = 4'd4;
    cfg_stride = 5'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(bz[0] && !pv[0], "busy_mid_mac", longint'(bz[0]), 1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk(!pv[k] && !bz[k] && !dn[k] && !er[k], "rst_mid_ctrl",
          longint'(bz[k]), 0);
    chk(pd0 == '0 && pd1 == '0 && pd2 == '0, "rst_mid_data",
        longint'($signed(pd0)), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_job(10, 4, 2, 1'b0, 1'b0, lat);
    chk(lat == 7, "latency_after_reset", longint'(lat), 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
